// File: rtl/tlu_pkg.sv
// Shared definitions for the TLU handshake controller: operating modes,
// FSM states, trigger-number width and the wrapping trigger-number increment.
package tlu_pkg;

  localparam int TRIG_NUM_W = 31;
  localparam int TIMEOUT_W  = 8;

  typedef enum logic [1:0] {
    MODE_DISABLED       = 2'd0,
    MODE_SIMPLE         = 2'd1,
    MODE_HANDSHAKE      = 2'd2,
    MODE_DATA_HANDSHAKE = 2'd3
  } tlu_mode_e;

  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    WAIT_TRIGGER_LOW = 3'd1,
    REQUEST_DATA     = 3'd2,
    WAIT_DATA        = 3'd3,
    DONE             = 3'd4
  } tlu_state_e;

  // Next trigger number; the 31-bit sum wraps 0x7FFFFFFF back to 0.
  function automatic logic [TRIG_NUM_W-1:0] trig_num_inc(input logic [TRIG_NUM_W-1:0] n);
    return n + TRIG_NUM_W'(1);
  endfunction

endpackage

// File: rtl/tlu_handshake_controller_if.sv
// TLU-side handshake bundle: trigger/busy lines plus the deserializer
// request/data/done signals. master = controller, slave = TLU + deserializer.
interface tlu_handshake_controller_if;
  import tlu_pkg::*;

  logic                  TLU_TRIGGER;
  logic                  TLU_BUSY;
  logic                  TLU_RECEIVE_DATA_FLAG;
  logic                  TLU_DATA_RECEIVED_FLAG;
  logic [TRIG_NUM_W-1:0] TLU_DATA;
  logic                  TLU_DATA_SAVE_FLAG;

  modport master (
    input  TLU_TRIGGER, TLU_DATA_RECEIVED_FLAG, TLU_DATA, TLU_DATA_SAVE_FLAG,
    output TLU_BUSY, TLU_RECEIVE_DATA_FLAG
  );

  modport slave (
    output TLU_TRIGGER, TLU_DATA_RECEIVED_FLAG, TLU_DATA, TLU_DATA_SAVE_FLAG,
    input  TLU_BUSY, TLU_RECEIVE_DATA_FLAG
  );

endinterface

// File: rtl/tlu_trigger_timeout.sv
// Trigger rising-edge detector and trigger-high timeout counter.
// The counter only runs in WAIT_TRIGGER_LOW and is held at zero in IDLE.
module tlu_trigger_timeout
  import tlu_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 trigger,
  input  logic                 in_idle,
  input  logic                 in_wait_low,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 trig_rise,
  output logic                 timeout_hit
);

  logic                 trig_d;
  logic [TIMEOUT_W-1:0] cnt;

  // Delayed trigger for edge detection.
  always_ff @(posedge CLK) begin
    if (!RESET_N) trig_d <= 1'b0;
    else          trig_d <= trigger;
  end

  // Count trigger-high cycles while waiting for the trigger to drop.
  always_ff @(posedge CLK) begin
    if (!RESET_N || in_idle)       cnt <= '0;
    else if (in_wait_low && trigger) cnt <= cnt + TIMEOUT_W'(1);
  end

  assign trig_rise = trigger & ~trig_d;

  // Fires on the high cycle that brings the count up to the limit.
  assign timeout_hit = in_wait_low & trigger & (limit != '0) &
                       (cnt == limit - TIMEOUT_W'(1));

endmodule

// File: rtl/tlu_handshake_controller.sv
// TLU trigger handshake controller: simple trigger counting, busy handshake
// and data handshake with trigger-number sequence checking.
module tlu_handshake_controller
  import tlu_pkg::*;
(
  input  logic                            CLK,
  input  logic                            RESET_N,
  input  logic [1:0]                      TLU_MODE,
  input  logic [TIMEOUT_W-1:0]            TLU_TRIGGER_LOW_TIMEOUT,
  input  logic                            ERROR_CLEAR,
  tlu_handshake_controller_if.master      tlu,
  output logic                            TRIGGER_ACCEPTED,
  output logic [TRIG_NUM_W-1:0]           TRIGGER_COUNTER,
  output logic                            TIMEOUT_ERROR,
  output logic                            NUMBER_MISMATCH_ERROR
);

  tlu_state_e            state, state_n;
  tlu_mode_e             mode_q, mode_n;
  logic                  busy_q, busy_n;
  logic                  recv_q, recv_n;
  logic                  acc_n;
  logic [TRIG_NUM_W-1:0] cnt_n;
  logic                  first_q, first_n;
  logic                  terr_set, merr_set;
  logic [TRIG_NUM_W-1:0] data_q, data_n, captured;
  logic                  trig_rise, timeout_hit;

  tlu_trigger_timeout u_trig (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .trigger     (tlu.TLU_TRIGGER),
    .in_idle     (state == IDLE),
    .in_wait_low (state == WAIT_TRIGGER_LOW),
    .limit       (TLU_TRIGGER_LOW_TIMEOUT),
    .trig_rise   (trig_rise),
    .timeout_hit (timeout_hit)
  );

  assign tlu.TLU_BUSY              = busy_q;
  assign tlu.TLU_RECEIVE_DATA_FLAG = recv_q;

  // Next state plus next values of every registered output; outputs are
  // derived from the next state so they line up with the state they belong to.
  always_comb begin
    state_n  = state;
    mode_n   = mode_q;
    cnt_n    = TRIGGER_COUNTER;
    first_n  = first_q;
    data_n   = data_q;
    acc_n    = 1'b0;
    terr_set = 1'b0;
    merr_set = 1'b0;
    captured = tlu.TLU_DATA_SAVE_FLAG ? tlu.TLU_DATA : data_q;

    case (state)
      IDLE: begin
        if (trig_rise) begin
          mode_n = tlu_mode_e'(TLU_MODE);
          case (tlu_mode_e'(TLU_MODE))
            MODE_SIMPLE: begin
              acc_n   = 1'b1;
              cnt_n   = trig_num_inc(TRIGGER_COUNTER);
              first_n = 1'b0;
            end
            MODE_HANDSHAKE, MODE_DATA_HANDSHAKE: state_n = WAIT_TRIGGER_LOW;
            default: ;
          endcase
        end
      end
      WAIT_TRIGGER_LOW: begin
        if (!tlu.TLU_TRIGGER) begin
          if (mode_q == MODE_DATA_HANDSHAKE) begin
            state_n = REQUEST_DATA;
          end else begin
            state_n = DONE;
            cnt_n   = trig_num_inc(TRIGGER_COUNTER);
          end
        end else if (timeout_hit) begin
          state_n  = IDLE;
          terr_set = 1'b1;
        end
      end
      REQUEST_DATA: state_n = WAIT_DATA;
      WAIT_DATA: begin
        if (tlu.TLU_DATA_SAVE_FLAG) data_n = tlu.TLU_DATA;
        if (tlu.TLU_DATA_RECEIVED_FLAG) begin
          state_n  = DONE;
          merr_set = !first_q && (captured != trig_num_inc(TRIGGER_COUNTER));
          cnt_n    = captured;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state_n == DONE) begin
      acc_n   = 1'b1;
      first_n = 1'b0;
    end
    busy_n = (state_n != IDLE);
    recv_n = (state_n == REQUEST_DATA);
  end

  // Control state and registered outputs; a new error outranks ERROR_CLEAR.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state                 <= IDLE;
      mode_q                <= MODE_DISABLED;
      busy_q                <= 1'b0;
      recv_q                <= 1'b0;
      TRIGGER_ACCEPTED      <= 1'b0;
      TRIGGER_COUNTER       <= '0;
      TIMEOUT_ERROR         <= 1'b0;
      NUMBER_MISMATCH_ERROR <= 1'b0;
      first_q               <= 1'b1;
    end else begin
      state                 <= state_n;
      mode_q                <= mode_n;
      busy_q                <= busy_n;
      recv_q                <= recv_n;
      TRIGGER_ACCEPTED      <= acc_n;
      TRIGGER_COUNTER       <= cnt_n;
      TIMEOUT_ERROR         <= terr_set | (TIMEOUT_ERROR & ~ERROR_CLEAR);
      NUMBER_MISMATCH_ERROR <= merr_set | (NUMBER_MISMATCH_ERROR & ~ERROR_CLEAR);
      first_q               <= first_n | ERROR_CLEAR;
    end
  end

  // Trigger-number capture register.
  always_ff @(posedge CLK) begin
    data_q <= data_n;
  end

endmodule

// File: tb/tb_tlu_handshake_controller.sv
// Bench for tlu_handshake_controller: directed scenarios, a deserializer
// model, and a scoreboard of expected TRIGGER_COUNTER values per accepted trigger.
module tb_tlu_handshake_controller;
  import tlu_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [1:0]  TLU_MODE;
  logic [7:0]  TLU_TRIGGER_LOW_TIMEOUT;
  logic        ERROR_CLEAR;
  logic        TRIGGER_ACCEPTED;
  logic [30:0] TRIGGER_COUNTER;
  logic        TIMEOUT_ERROR;
  logic        NUMBER_MISMATCH_ERROR;

  tlu_handshake_controller_if bus ();

  tlu_handshake_controller dut (
    .CLK                     (CLK),
    .RESET_N                 (RESET_N),
    .TLU_MODE                (TLU_MODE),
    .TLU_TRIGGER_LOW_TIMEOUT (TLU_TRIGGER_LOW_TIMEOUT),
    .ERROR_CLEAR             (ERROR_CLEAR),
    .tlu                     (bus),
    .TRIGGER_ACCEPTED        (TRIGGER_ACCEPTED),
    .TRIGGER_COUNTER         (TRIGGER_COUNTER),
    .TIMEOUT_ERROR           (TIMEOUT_ERROR),
    .NUMBER_MISMATCH_ERROR   (NUMBER_MISMATCH_ERROR)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  int n_recv = 0;
  bit busy_seen = 1'b0;
  logic [30:0] exp_q[$];
  logic [30:0] deser_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted trigger must match the next expected count.
  initial begin
    logic [30:0] e;
    forever begin
      @(negedge CLK);
      if (bus.TLU_BUSY) busy_seen = 1'b1;
      if (bus.TLU_RECEIVE_DATA_FLAG) n_recv++;
      if (TRIGGER_ACCEPTED) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          check("unexpected_accept", 32'(TRIGGER_COUNTER), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("accept_counter", 32'(TRIGGER_COUNTER), 32'(e));
        end
      end
    end
  end

  // Deserializer model: answers each data request with the next queued number.
  initial begin
    bus.TLU_DATA_SAVE_FLAG     = 1'b0;
    bus.TLU_DATA_RECEIVED_FLAG = 1'b0;
    bus.TLU_DATA               = '0;
    forever begin
      @(negedge CLK);
      if (bus.TLU_RECEIVE_DATA_FLAG) begin
        repeat (2) @(negedge CLK);
        bus.TLU_DATA           = (deser_q.size() != 0) ? deser_q.pop_front() : 31'd0;
        bus.TLU_DATA_SAVE_FLAG = 1'b1;
        @(negedge CLK);
        bus.TLU_DATA_SAVE_FLAG     = 1'b0;
        bus.TLU_DATA_RECEIVED_FLAG = 1'b1;
        @(negedge CLK);
        bus.TLU_DATA_RECEIVED_FLAG = 1'b0;
      end
    end
  end

  task automatic do_reset();
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic pulse_trigger(input int high);
    bus.TLU_TRIGGER = 1'b1;
    repeat (high) @(negedge CLK);
    bus.TLU_TRIGGER = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.TLU_BUSY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) check("wait_idle_timeout", 32'(n), 32'd0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic hs_trigger(input int high, input logic [30:0] exp_cnt);
    exp_q.push_back(exp_cnt);
    pulse_trigger(high);
    wait_idle();
  endtask

  task automatic data_trigger(input logic [30:0] num);
    deser_q.push_back(num);
    exp_q.push_back(num);
    pulse_trigger(2);
    wait_idle();
  endtask

  initial begin
    int acc_snap;
    RESET_N = 1'b0;
    TLU_MODE = 2'd0;
    TLU_TRIGGER_LOW_TIMEOUT = 8'd10;
    ERROR_CLEAR = 1'b0;
    bus.TLU_TRIGGER = 1'b0;
    do_reset();

    check("rst_busy", 32'(bus.TLU_BUSY), 32'd0);
    check("rst_recv", 32'(bus.TLU_RECEIVE_DATA_FLAG), 32'd0);
    check("rst_accepted", 32'(TRIGGER_ACCEPTED), 32'd0);
    check("rst_counter", 32'(TRIGGER_COUNTER), 32'd0);
    check("rst_timeout_err", 32'(TIMEOUT_ERROR), 32'd0);
    check("rst_mismatch_err", 32'(NUMBER_MISMATCH_ERROR), 32'd0);

    // Disabled mode ignores triggers.
    busy_seen = 1'b0;
    pulse_trigger(2);
    repeat (4) @(negedge CLK);
    check("mode0_counter", 32'(TRIGGER_COUNTER), 32'd0);
    check("mode0_busy", 32'(busy_seen), 32'd0);

    // Simple trigger mode: three 2-cycle pulses.
    TLU_MODE = 2'd1;
    busy_seen = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(31'(i));
      pulse_trigger(2);
      repeat (2) @(negedge CLK);
    end
    repeat (2) @(negedge CLK);
    check("mode1_counter", 32'(TRIGGER_COUNTER), 32'd3);
    check("mode1_busy_never", 32'(busy_seen), 32'd0);

    // Handshake mode, trigger high 5 cycles, timeout 10.
    do_reset();
    TLU_MODE = 2'd2;
    TLU_TRIGGER_LOW_TIMEOUT = 8'd10;
    exp_q.push_back(31'd1);
    bus.TLU_TRIGGER = 1'b1;
    @(negedge CLK);
    check("mode2_busy_rise", 32'(bus.TLU_BUSY), 32'd1);
    repeat (4) @(negedge CLK);
    check("mode2_busy_held", 32'(bus.TLU_BUSY), 32'd1);
    bus.TLU_TRIGGER = 1'b0;
    wait_idle();
    check("mode2_counter", 32'(TRIGGER_COUNTER), 32'd1);
    check("mode2_timeout_err", 32'(TIMEOUT_ERROR), 32'd0);

    // Mode change mid-transaction keeps the latched handshake mode.
    exp_q.push_back(31'd2);
    bus.TLU_TRIGGER = 1'b1;
    @(negedge CLK);
    TLU_MODE = 2'd1;
    repeat (2) @(negedge CLK);
    bus.TLU_TRIGGER = 1'b0;
    wait_idle();
    check("mode_change_counter", 32'(TRIGGER_COUNTER), 32'd2);
    TLU_MODE = 2'd2;

    // Timeout: trigger high 20 cycles, limit 8; clear coincides with the error.
    TLU_TRIGGER_LOW_TIMEOUT = 8'd8;
    bus.TLU_TRIGGER = 1'b1;
    repeat (8) @(negedge CLK);
    check("to_busy_before", 32'(bus.TLU_BUSY), 32'd1);
    check("to_err_before", 32'(TIMEOUT_ERROR), 32'd0);
    ERROR_CLEAR = 1'b1;
    @(negedge CLK);
    ERROR_CLEAR = 1'b0;
    check("to_err_set", 32'(TIMEOUT_ERROR), 32'd1);
    check("to_busy_low", 32'(bus.TLU_BUSY), 32'd0);
    repeat (11) @(negedge CLK);
    bus.TLU_TRIGGER = 1'b0;
    repeat (3) @(negedge CLK);
    check("to_counter_kept", 32'(TRIGGER_COUNTER), 32'd2);
    check("to_err_sticky", 32'(TIMEOUT_ERROR), 32'd1);
    ERROR_CLEAR = 1'b1;
    @(negedge CLK);
    ERROR_CLEAR = 1'b0;
    check("to_err_cleared", 32'(TIMEOUT_ERROR), 32'd0);

    // Data handshake: 5, 6 in sequence, then 9 out of sequence.
    do_reset();
    TLU_MODE = 2'd3;
    TLU_TRIGGER_LOW_TIMEOUT = 8'd0;
    data_trigger(31'd5);
    data_trigger(31'd6);
    check("m3_counter_6", 32'(TRIGGER_COUNTER), 32'd6);
    check("m3_no_mismatch", 32'(NUMBER_MISMATCH_ERROR), 32'd0);
    data_trigger(31'd9);
    check("m3_counter_9", 32'(TRIGGER_COUNTER), 32'd9);
    check("m3_mismatch", 32'(NUMBER_MISMATCH_ERROR), 32'd1);
    check("m3_recv_pulses", 32'(n_recv), 32'd3);

    // Wrap-around sequence, then reset during WAIT_DATA.
    do_reset();
    data_trigger(31'h7FFF_FFFF);
    check("wrap_counter_max", 32'(TRIGGER_COUNTER), 32'h7FFF_FFFF);
    data_trigger(31'd0);
    check("wrap_counter_zero", 32'(TRIGGER_COUNTER), 32'd0);
    check("wrap_no_mismatch", 32'(NUMBER_MISMATCH_ERROR), 32'd0);
    data_trigger(31'd1);
    check("pre_abort_counter", 32'(TRIGGER_COUNTER), 32'd1);
    acc_snap = n_acc;
    deser_q.push_back(31'd2);
    pulse_trigger(2);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    check("abort_busy", 32'(bus.TLU_BUSY), 32'd0);
    check("abort_counter", 32'(TRIGGER_COUNTER), 32'd0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK);
    check("abort_no_accept", 32'(n_acc), 32'(acc_snap));
    check("abort_busy_after", 32'(bus.TLU_BUSY), 32'd0);
    check("total_recv_pulses", 32'(n_recv), 32'd7);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/tlu_handshake_controller.md
TLU_HANDSHAKE_CONTROLLER -- requirements
Module: tlu_handshake_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: reset asserted when RESET_N is low, sampled on the rising edge of CLK.
REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK  in  1  system clock.
- RESET_N  in  1  synchronous active-low reset.
- TLU_MODE  in  2  0 = disabled, 1 = simple trigger, 2 = handshake, 3 = data handshake.
- TLU_TRIGGER_LOW_TIMEOUT  in  8  max cycles TLU_TRIGGER may stay high while BUSY is asserted; 0 disables the timeout.
- ERROR_CLEAR  in  1  single-cycle pulse; clears sticky errors and the first-trigger state.
- TLU_TRIGGER  in  1  external trigger, already synchronized to CLK.
- TLU_BUSY  out  1  busy line to the TLU.
- TLU_RECEIVE_DATA_FLAG  out  1  single-cycle request to the deserializer to clock in the trigger number.
- TLU_DATA_RECEIVED_FLAG  in  1  deserializer done pulse.
- TLU_DATA  in  31  trigger number from the deserializer.
- TLU_DATA_SAVE_FLAG  in  1  TLU_DATA is valid in this cycle.
- TRIGGER_ACCEPTED  out  1  single-cycle pulse per completed trigger.
- TRIGGER_COUNTER  out  31  accepted-trigger count, or the last received trigger number in mode 3.
- TIMEOUT_ERROR  out  1  sticky.
- NUMBER_MISMATCH_ERROR  out  1  sticky.

Function
REQ-003 The block SHALL register TLU_TRIGGER into trig_d; a rising edge is defined as trig_rise = TLU_TRIGGER & ~trig_d.
REQ-004 The FSM SHALL have these states: IDLE, WAIT_TRIGGER_LOW, REQUEST_DATA, WAIT_DATA, DONE.
REQ-005 TLU_MODE SHALL be sampled only in IDLE on trig_rise; the latched mode SHALL govern the transaction until the FSM returns to IDLE.
- A mode change during a transaction has no effect on that transaction.
REQ-006 In IDLE with TLU_MODE=0, trig_rise SHALL be ignored.
REQ-007 Mode 1 (simple trigger):
- trig_rise in IDLE SHALL pulse TRIGGER_ACCEPTED on the next cycle and increment TRIGGER_COUNTER.
- The FSM stays in IDLE and TLU_BUSY stays low.
REQ-008 Modes 2 and 3: trig_rise SHALL move the FSM to WAIT_TRIGGER_LOW.
- TLU_BUSY goes high 1 cycle after trig_rise and stays high until DONE is left.
REQ-009 In WAIT_TRIGGER_LOW, the timeout counter SHALL increment each cycle TLU_TRIGGER=1.
- When TLU_TRIGGER=0: mode 2 SHALL go to DONE; mode 3 SHALL go to REQUEST_DATA.
REQ-010 If TLU_TRIGGER_LOW_TIMEOUT≠0 and the timeout counter reaches that value while TLU_TRIGGER=1, the block SHALL:
- set TIMEOUT_ERROR;
- go to IDLE with TLU_BUSY low, without pulsing TRIGGER_ACCEPTED and without changing TRIGGER_COUNTER.
REQ-011 REQUEST_DATA SHALL assert TLU_RECEIVE_DATA_FLAG for exactly one cycle, then go to WAIT_DATA.
REQ-012 In WAIT_DATA:
- on TLU_DATA_SAVE_FLAG, TLU_DATA SHALL be captured;
- on TLU_DATA_RECEIVED_FLAG, the FSM SHALL go to DONE.
- There is no timeout in WAIT_DATA.
REQ-013 Mode 3 sequence check: if this is not the first trigger and the captured number ≠ (TRIGGER_COUNTER+1) mod 2^31, the block SHALL set NUMBER_MISMATCH_ERROR.
- TRIGGER_COUNTER SHALL then be loaded with the captured number, whether or not a mismatch occurred.
REQ-014 DONE SHALL last one cycle.
- It pulses TRIGGER_ACCEPTED; in mode 2 it also increments TRIGGER_COUNTER.
- It then returns to IDLE with TLU_BUSY low on the following cycle.
REQ-015 TRIGGER_COUNTER SHALL wrap from 0x7FFFFFFF to 0.
REQ-016 A trig_rise outside IDLE SHALL be ignored.
- Exception: a rising edge coincident with the DONE→IDLE transition is not captured.
REQ-017 ERROR_CLEAR SHALL clear both sticky errors and set the first-trigger flag, in any state.
- If ERROR_CLEAR coincides with a new error, the error SHALL win.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 While RESET_N=0, the following SHALL hold at the next CLK edge:
- state=IDLE;
- TLU_BUSY, TLU_RECEIVE_DATA_FLAG, TRIGGER_ACCEPTED, TIMEOUT_ERROR and NUMBER_MISMATCH_ERROR = 0;
- TRIGGER_COUNTER = 0, trig_d = 0, timeout counter = 0;
- first-trigger flag = 1.
REQ-020 Reset asserted mid-transaction SHALL abort it: TLU_BUSY drops, and no TRIGGER_ACCEPTED pulse is produced.

Structure
REQ-021 Mode encodings (MODE_DISABLED, MODE_SIMPLE, MODE_HANDSHAKE, MODE_DATA_HANDSHAKE), the state enumeration and the 31-bit trigger-number width constant SHALL reside in the shared package tlu_pkg.
REQ-022 The edge detector and timeout counter SHALL form one sub-module, tlu_trigger_timeout.
- It outputs trig_rise and timeout_hit.
- It is cleared whenever the FSM is in IDLE.

Verification
REQ-023 Mode 1, three trigger pulses 2 cycles high → 3 TRIGGER_ACCEPTED pulses, TRIGGER_COUNTER=3, TLU_BUSY never high.
REQ-024 Mode 2, trigger held high 5 cycles, timeout=10 → BUSY high from cycle 1 to release, TRIGGER_ACCEPTED once, TRIGGER_COUNTER=1, TIMEOUT_ERROR=0.
REQ-025 Mode 2, trigger held high 20 cycles, timeout=8 → TIMEOUT_ERROR=1 after 8 high cycles in WAIT_TRIGGER_LOW, BUSY low, TRIGGER_COUNTER unchanged; ERROR_CLEAR → TIMEOUT_ERROR=0.
REQ-026 Mode 3, model returns trigger numbers 5 then 6 → one RECEIVE_DATA_FLAG pulse per trigger, TRIGGER_COUNTER=6, NUMBER_MISMATCH_ERROR=0; a following number 9 → NUMBER_MISMATCH_ERROR=1, TRIGGER_COUNTER=9.
REQ-027 Mode 3, data 0x7FFFFFFF then 0 → no mismatch (wrap-around); RESET_N low during WAIT_DATA → BUSY=0, counter=0, no TRIGGER_ACCEPTED pulse.
